// File: rtl/fb_arbiter.sv
// Framebuffer port arbiter: scanout reads, back-bank clear and renderer writes share one RAM port.
// Define FB_ARB_CLEAR_EN to build the back-bank clear engine; without it swaps go straight to RUN.
module fb_arbiter #(
    parameter int unsigned FB_WORDS = 518400,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              clk_vga,
    input  logic              reset_n,
    input  logic              frame_toggle,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [23:0]       rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    output logic              wr_ack,
    output logic [ADDR_W:0]   mem_addr,
    output logic              mem_we,
    output logic [23:0]       mem_wdata,
    input  logic [23:0]       mem_rdata,
    output logic              clear_busy,
    output logic              clear_overrun
);

    typedef enum logic [1:0] {StIdle, StClear, StRun} state_e;

    state_e            state_q, state_d;
    logic              front_q, front_d;
    logic              front_cur;
    logic              swap;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_ack_q, wr_ack_d;
    logic [ADDR_W:0]   mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [23:0]       mem_wdata_q, mem_wdata_d;
    logic              clr_wr;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_grant;
    logic              wr_in_range;

`ifdef FB_ARB_CLEAR_EN
    localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(FB_WORDS - 1);

    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              clear_busy_q, clear_busy_d;
    logic              clear_overrun_q, clear_overrun_d;

    assign clr_addr = clr_cnt_q;
`else
    assign clr_addr = '0;
`endif

    // front_q only becomes meaningful after the first clock out of reset; until then
    // the live frame_toggle level stands in for it.
    assign front_cur   = (state_q == StIdle) ? frame_toggle : front_q;
    assign swap        = (state_q != StIdle) && (frame_toggle != front_q);
    assign wr_in_range = 32'(wr_addr) < FB_WORDS;
    // The ack cycle still shows the old request, so it must not be granted twice.
    assign wr_grant    = (state_q == StRun) && wr_req && !rd_req && !wr_ack_q && !swap;

    always_comb begin
        state_d     = state_q;
        front_d     = frame_toggle;
        rd_pend_d   = rd_req;
        rd_valid_d  = rd_pend_q;
        wr_ack_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        clr_wr      = 1'b0;
`ifdef FB_ARB_CLEAR_EN
        clr_cnt_d       = clr_cnt_q;
        clear_overrun_d = clear_overrun_q;
`endif

        unique case (state_q)
            StIdle: state_d = StRun;
            StRun: begin
`ifdef FB_ARB_CLEAR_EN
                if (swap) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                end
`endif
            end
`ifdef FB_ARB_CLEAR_EN
            StClear: begin
                // A swap mid-sweep restarts on the new back bank; no write that cycle.
                if (swap) begin
                    clr_cnt_d       = '0;
                    clear_overrun_d = 1'b1;
                end else if (!rd_req) begin
                    clr_wr = 1'b1;
                    if (clr_cnt_q == LastWord) begin
                        state_d   = StRun;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (rd_req) begin
            mem_addr_d  = {front_cur, rd_addr};
            mem_wdata_d = '0;
        end else if (clr_wr) begin
            mem_addr_d  = {~front_q, clr_addr};
            mem_we_d    = 1'b1;
            mem_wdata_d = '0;
        end else if (wr_grant) begin
            wr_ack_d = 1'b1;
            if (wr_in_range) begin
                mem_addr_d  = {~front_q, wr_addr};
                mem_we_d    = 1'b1;
                mem_wdata_d = wr_data;
            end
        end

`ifdef FB_ARB_CLEAR_EN
        clear_busy_d = (state_d == StClear);
`endif
    end

    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            front_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            wr_ack_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
`ifdef FB_ARB_CLEAR_EN
            clr_cnt_q       <= '0;
            clear_busy_q    <= 1'b0;
            clear_overrun_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            front_q     <= front_d;
            rd_pend_q   <= rd_pend_d;
            rd_valid_q  <= rd_valid_d;
            wr_ack_q    <= wr_ack_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef FB_ARB_CLEAR_EN
            clr_cnt_q       <= clr_cnt_d;
            clear_busy_q    <= clear_busy_d;
            clear_overrun_q <= clear_overrun_d;
`endif
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_valid_q ? mem_rdata : '0;
    assign wr_ack    = wr_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

`ifdef FB_ARB_CLEAR_EN
    assign clear_busy    = clear_busy_q;
    assign clear_overrun = clear_overrun_q;
`else
    assign clear_busy    = 1'b0;
    assign clear_overrun = 1'b0;
`endif

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter FB_WORDS, default 518400: words per bank (720x720).
REQ-002 SHALL have parameter ADDR_W, default 19: per-bank word address width.
REQ-003 SHALL have port clk_vga, input, 1: clock; all logic rising-edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port frame_toggle, input, 1: bank select from scanout (hold_frame); front bank = current level.
REQ-006 SHALL have port rd_req, input, 1: scanout read request, one word per cycle, never stalled.
REQ-007 SHALL have port rd_addr, input, ADDR_W: scanout word address.
REQ-008 SHALL have port rd_data, output, 24: read word.
REQ-009 SHALL have port rd_valid, output, 1: rd_data valid strobe.
REQ-010 SHALL have port wr_req, input, 1: renderer write request, held until wr_ack.
REQ-011 SHALL have port wr_addr, input, ADDR_W: renderer word address.
REQ-012 SHALL have port wr_data, input, 24: renderer pixel.
REQ-013 SHALL have port wr_ack, output, 1: one-cycle write-accepted pulse.
REQ-014 SHALL have port mem_addr, output, ADDR_W+1: {bank, word} to framebuffer RAM, registered.
REQ-015 SHALL have port mem_we, output, 1: RAM write enable, registered.
REQ-016 SHALL have port mem_wdata, output, 24: RAM write data, registered.
REQ-017 SHALL have port mem_rdata, input, 24: RAM read data, valid one cycle after mem_addr.
REQ-018 SHALL have port clear_busy, output, 1: back-bank clear in progress.
REQ-019 SHALL have port clear_overrun, output, 1: sticky; swap arrived while clearing.

Function
REQ-020 SHALL register frame_toggle into front_q; swap event = frame_toggle != front_q, front_q updated the same cycle.
REQ-021 SHALL address reads to bank front_q and writes/clears to bank ~front_q, as evaluated in the grant cycle.
REQ-022 SHALL use fixed priority per cycle: read > clear > renderer write; one RAM access per cycle.
REQ-023 SHALL, for rd_req in cycle N, drive mem_addr={front_q,rd_addr}, mem_we=0 at N+1 and rd_valid=1 with rd_data=mem_rdata at N+2.
REQ-024 SHALL pipeline reads fully: back-to-back rd_req yields back-to-back rd_valid.
REQ-025 SHALL have states IDLE, CLEAR, RUN; IDLE after reset; IDLE->RUN on first swap event, or on the first cycle after reset when frame_toggle is already stable.
REQ-026 SHALL, in CLEAR, write 24'h0 to {~front_q, clr_cnt} on each cycle without rd_req, incrementing clr_cnt; after writing FB_WORDS-1, go to RUN and drop clear_busy the next cycle.
REQ-027 SHALL, on a swap event in RUN, enter CLEAR with clr_cnt=0 (with clear enabled, REQ-038).
REQ-028 SHALL, on a swap event in CLEAR, restart clr_cnt at 0 on the new back bank and set clear_overrun.
REQ-029 SHALL grant a renderer write only in RUN, with wr_req high and no rd_req; wr_ack pulses the cycle mem_we=1 is driven with {~front_q,wr_addr},wr_data.
REQ-030 SHALL never issue wr_ack while wr_req is low; the renderer deasserts wr_req or presents a new request the cycle after wr_ack.
REQ-031 SHALL keep clr_cnt ADDR_W bits wide with no wrap past FB_WORDS-1.
REQ-032 SHALL ignore out-of-range wr_addr (>= FB_WORDS): ack without mem_we.

Reset
REQ-033 SHALL, on reset_n low, immediately force rd_data=0, rd_valid=0, wr_ack=0, mem_addr=0, mem_we=0, mem_wdata=0, clear_busy=0, clear_overrun=0, clr_cnt=0, state IDLE, front_q=frame_toggle sampled at reset release.
REQ-034 SHALL abandon in-flight reads and clears on reset mid-operation; nothing resumes afterwards.
REQ-035 SHALL clear clear_overrun only by reset.

Configuration
REQ-036 SHALL compile the clear engine only when macro FB_ARB_CLEAR_EN is defined.
REQ-037 SHALL, with FB_ARB_CLEAR_EN: behave per REQ-026..REQ-028.
REQ-038 SHALL, without FB_ARB_CLEAR_EN: swap events go straight to RUN, and clear_busy and clear_overrun are tied 0.

Verification
REQ-039 SHALL test a read: frame_toggle=1, rd_req at N with rd_addr=5 -> mem_addr=20'h80005 at N+1, rd_valid at N+2 with rd_data=mem_rdata.
REQ-040 SHALL test read-vs-write collision: rd_req and wr_req (addr 7, data 24'hFF0000) together -> read granted; write granted the first cycle rd_req=0, mem_addr={~front,7}, wr_ack the same cycle.
REQ-041 SHALL test a clear sweep: FB_WORDS=16, swap with no reads -> 16 consecutive zero writes to the back bank, clear_busy low afterwards, wr_ack suppressed throughout.
REQ-042 SHALL test clear with reads: rd_req every other cycle during the sweep -> clear completes in 32 cycles and reads are undisturbed.
REQ-043 SHALL test a double swap: second toggle at clr_cnt=9 -> clr_cnt restarts at 0 on the other bank, clear_overrun=1 sticky.
REQ-044 SHALL test reset mid-clear: reset_n low at clr_cnt=4 -> all outputs 0 and no mem_we after release until the next swap or write.
